spi_transmitter: RTL and testbench
==================================

# spi_transmitter

Slave-side SPI transmitter driving the serial data output (MISO) from an externally generated ss/sclk pair, the counterpart of spi_receiver on the same bus. It accepts a parallel word through a ready/load handshake, then shifts it out bit by bit on the edges of the synchronized sclk. Mode is selected with the same polarity and phase parameters spi_receiver uses, so both blocks can share one SPI port.

## Interface
- bitcount, 8: word length in bits (≥2)
- ss_polarity, 1: ss level meaning "selected"
- sclk_polarity, 0: sclk idle level; the leading edge leaves idle, the trailing edge returns to it
- sclk_phase, 1: 0 = master samples on leading edge; 1 = master samples on trailing edge
- msb_first, 1: 1 = bit bitcount-1 first; 0 = bit 0 first
- use_gated_output, 1: 1 = sdo forced 0 while deselected; 0 = sdo holds its last value
- clock  input  1  system clock; the only clock
- reset_n  input  1  synchronous, active-low reset
- data  input  bitcount  word to transmit
- load  input  1  captures data when ready=1
- ready  output  1  a word can be accepted
- ss  input  1  slave select, asynchronous
- sclk  input  1  serial clock, asynchronous
- sdo  output  1  serial data out
- sdo_enable  output  1  1 while selected; tristate control for top level
- busy  output  1  frame in progress (selected)
- done  output  1  one-cycle pulse: full word sampled by master
- underrun  output  1  one-cycle pulse: frame started or continued with no word loaded

## Operation
- ss and sclk pass through 2-flop synchronizers plus one history register; edges are detected on synchronized values.
- Selected = synchronized ss == ss_polarity. busy = sdo_enable = selected.
- Shift-register state: empty/full flag. load with ready=1 → shift register := data, flag full. load with ready=0 ignored, no state change.
- ready = !full && !selected.
- Frame start (selected rising): if full, transmission begins; if empty, underrun pulses and zeros are sent.
- sclk_phase=0: first bit drives sdo on frame start; next bit on each trailing edge.
- sclk_phase=1: first bit drives sdo on the first leading edge; next bit on each subsequent leading edge.
- Bit counter (0..bitcount) increments on each sampling edge (leading for phase 0, trailing for phase 1). At bitcount: done pulses, flag := empty, counter := 0.
- Further sampling edges in the same frame with an empty register: sdo = 0; underrun pulses once on the first such edge.
- ss deselected mid-word: frame aborted, counter := 0, word discarded (flag empty), no done, no underrun.
- Reset: shift register 0, flag empty, counter 0, sdo 0, sdo_enable 0, busy 0, ready 1, done 0, underrun 0. Reset overrides every other event.

## Timing
- Pin edge to internal edge detection: 3 clock cycles. sdo updates on the same cycle the edge is detected.
- Requirement on master: sclk high and low phases ≥ 4 clock cycles each; ss-assert to first sclk edge ≥ 4 clock cycles; ss-deassert after last trailing edge ≥ 4 clock cycles.
- done asserts 3 cycles after the bitcount-th sampling edge at the pin; ready rises 3 cycles after the ss deselect pin edge.
- Frame start/end and edge detection coinciding in one cycle: frame end wins; edge is ignored.

## Configuration
- SPI_TRANSMITTER_DOUBLE_BUFFER_EN defined: adds a bitcount-wide holding register. ready = holding register empty (independent of selected). At done, a full holding word moves into the shift register at once, enabling back-to-back words within one frame with no underrun. An abort clears only the shift register.
- Undefined: single buffer, behaviour as above.

## Structure
- Shared package spi_pkg: mode constants (polarity/phase encodings) shared with spi_receiver and spi_stimulus.
- One sub-module: spi_input_sync (2-flop synchronizer plus edge detector, reused for ss and sclk, outputs level, rise, fall).

## Test plan
- Defaults, clock 4× stimulus clock, load 8'hA5 then frame → sdo sequence 1,0,1,0,0,1,0,1; one done pulse; ready back to 1 after deselect.
- Frame with nothing loaded → underrun pulse at frame start, sdo constantly 0, no done.
- sclk_phase=0, msb_first=0, load 8'h01 → sdo = 1 at frame start before first sclk edge, then seven 0s.
- ss deselected after 3 sampling edges → no done; ready=1; next frame with no new load → underrun.
- load asserted during a frame (single buffer) → ignored; word sent is the earlier one.
- With SPI_TRANSMITTER_DOUBLE_BUFFER_EN: load 8'h3C, then 8'hC3 mid-frame, 16 sclk periods → 16 bits 3C then C3, two done pulses, no underrun.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI mode encodings used by spi_receiver, spi_transmitter and spi_stimulus,
// plus a helper that classifies a synchronized sclk edge as leading or trailing.
package spi_pkg;

   localparam logic SS_ACTIVE_HIGH        = 1'b1;
   localparam logic SCLK_IDLE_LOW         = 1'b0;
   localparam logic PHASE_SAMPLE_LEADING  = 1'b0;
   localparam logic PHASE_SAMPLE_TRAILING = 1'b1;
   localparam logic ORDER_MSB_FIRST       = 1'b1;

   typedef enum logic [1:0] {
      SCLK_NO_EDGE,
      SCLK_LEADING,
      SCLK_TRAILING
   } sclk_edge_t;

   // An edge that lands on the idle level returns to idle, so it is the trailing one.
   function automatic sclk_edge_t classify_sclk(input logic level, input logic rise,
                                                input logic fall, input logic idle_level);
      if (!(rise | fall))
         return SCLK_NO_EDGE;
      return (level == idle_level) ? SCLK_TRAILING : SCLK_LEADING;
   endfunction

endpackage

// File: rtl/spi_transmitter_if.sv
// Parallel handshake, status and SPI pin bundle for spi_transmitter.
interface spi_transmitter_if #(
   parameter int unsigned bitcount = 8
);
   logic [bitcount-1:0] data;
   logic                load;
   logic                ready;
   logic                ss;
   logic                sclk;
   logic                sdo;
   logic                sdo_enable;
   logic                busy;
   logic                done;
   logic                underrun;

   modport master (
      output data, load, ss, sclk,
      input  ready, sdo, sdo_enable, busy, done, underrun
   );

   modport slave (
      input  data, load, ss, sclk,
      output ready, sdo, sdo_enable, busy, done, underrun
   );
endinterface

// File: rtl/spi_input_sync.sv
// Two-flop synchronizer plus history register; reports the synchronized level
// and single-cycle rise/fall strobes derived from it.
module spi_input_sync #(
   parameter logic reset_level = 1'b0
) (
   input  logic clock,
   input  logic reset_n,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [1:0] sync;
   logic       hist;

   // Synchronize the pin and keep one cycle of history for edge detection.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sync <= {2{reset_level}};
         hist <= reset_level;
      end else begin
         sync <= {sync[0], async_in};
         hist <= sync[1];
      end
   end

   assign level = sync[1];
   assign rise  = sync[1] & ~hist;
   assign fall  = ~sync[1] & hist;

endmodule

// File: rtl/spi_transmitter.sv
// Slave-side SPI transmitter: drives sdo from an external ss/sclk pair.
// Optional feature macro: SPI_TRANSMITTER_DOUBLE_BUFFER_EN (adds a holding
// register so consecutive words can follow each other within one frame).
module spi_transmitter
   import spi_pkg::*;
#(
   parameter int unsigned bitcount         = 8,
   parameter logic        ss_polarity      = SS_ACTIVE_HIGH,
   parameter logic        sclk_polarity    = SCLK_IDLE_LOW,
   parameter logic        sclk_phase       = PHASE_SAMPLE_TRAILING,
   parameter logic        msb_first        = ORDER_MSB_FIRST,
   parameter logic        use_gated_output = 1'b1
) (
   input  logic               clock,
   input  logic               reset_n,
   spi_transmitter_if.slave   bus
);

   localparam int unsigned   CW   = $clog2(bitcount);
   localparam logic [CW-1:0] LAST = CW'(bitcount - 1);

   logic ss_lvl, ss_rise, ss_fall;
   logic sclk_lvl, sclk_rise, sclk_fall;

   spi_input_sync #(.reset_level(!ss_polarity)) u_ss_sync (
      .clock    (clock),
      .reset_n  (reset_n),
      .async_in (bus.ss),
      .level    (ss_lvl),
      .rise     (ss_rise),
      .fall     (ss_fall)
   );

   spi_input_sync #(.reset_level(sclk_polarity)) u_sclk_sync (
      .clock    (clock),
      .reset_n  (reset_n),
      .async_in (bus.sclk),
      .level    (sclk_lvl),
      .rise     (sclk_rise),
      .fall     (sclk_fall)
   );

   logic [bitcount-1:0] shreg;
   logic [bitcount-1:0] shreg_shifted;
   logic                full;
   logic                active;
   logic                ur_seen;
   logic                sdo_r;
   logic                done_r;
   logic                underrun_r;
   logic [CW-1:0]       cnt;
   logic                frame_start;
   logic                frame_end;
   logic                edge_ok;
   logic                sample_edge;
   logic                shift_edge;
   logic                head;
   logic                head_next;
   sclk_edge_t          sclk_edge;

`ifdef SPI_TRANSMITTER_DOUBLE_BUFFER_EN
   logic [bitcount-1:0] hold;
   logic                hold_full;
`endif

   // Decode frame boundaries, qualified sclk edges and the bit at the head of the shifter.
   always_comb begin
      frame_start = (ss_rise | ss_fall) & (ss_lvl == ss_polarity);
      frame_end   = (ss_rise | ss_fall) & (ss_lvl != ss_polarity);
      sclk_edge   = classify_sclk(sclk_lvl, sclk_rise, sclk_fall, sclk_polarity);
      // an sclk edge seen together with a frame boundary is dropped
      edge_ok     = active & !(ss_rise | ss_fall);
      if (sclk_phase == PHASE_SAMPLE_LEADING) begin
         sample_edge = edge_ok && (sclk_edge == SCLK_LEADING);
         shift_edge  = edge_ok && (sclk_edge == SCLK_TRAILING);
      end else begin
         sample_edge = edge_ok && (sclk_edge == SCLK_TRAILING);
         shift_edge  = edge_ok && (sclk_edge == SCLK_LEADING);
      end
      if (msb_first) begin
         head          = shreg[bitcount-1];
         head_next     = shreg[bitcount-2];
         shreg_shifted = {shreg[bitcount-2:0], 1'b0};
      end else begin
         head          = shreg[0];
         head_next     = shreg[1];
         shreg_shifted = {1'b0, shreg[bitcount-1:1]};
      end
   end

   // Word buffering, frame tracking, bit shifting and status pulses.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         shreg      <= '0;
         full       <= 1'b0;
         cnt        <= '0;
         active     <= 1'b0;
         ur_seen    <= 1'b0;
         sdo_r      <= 1'b0;
         done_r     <= 1'b0;
         underrun_r <= 1'b0;
`ifdef SPI_TRANSMITTER_DOUBLE_BUFFER_EN
         hold       <= '0;
         hold_full  <= 1'b0;
`endif
      end else begin
         done_r     <= 1'b0;
         underrun_r <= 1'b0;
`ifdef SPI_TRANSMITTER_DOUBLE_BUFFER_EN
         if (bus.load && !hold_full) begin
            hold      <= bus.data;
            hold_full <= 1'b1;
         end
         // between frames the holding word drops straight into an empty shifter
         if (hold_full && !full && !active) begin
            shreg     <= hold;
            full      <= 1'b1;
            hold_full <= 1'b0;
         end
`else
         if (bus.load && !full && !active) begin
            shreg <= bus.data;
            full  <= 1'b1;
         end
`endif
         if (frame_end) begin
            active  <= 1'b0;
            ur_seen <= 1'b0;
            if (cnt != '0) begin
               shreg <= '0;
               full  <= 1'b0;
               cnt   <= '0;
            end
         end else if (frame_start) begin
            active <= 1'b1;
            if (full) begin
               if (sclk_phase == PHASE_SAMPLE_LEADING)
                  sdo_r <= head;
            end else begin
               underrun_r <= 1'b1;
               ur_seen    <= 1'b1;
               if (sclk_phase == PHASE_SAMPLE_LEADING)
                  sdo_r <= 1'b0;
            end
         end else begin
            // cnt==0 means the head bit has not been presented yet for this word
            if (shift_edge) begin
               if (!full)
                  sdo_r <= 1'b0;
               else if (cnt == '0)
                  sdo_r <= head;
               else begin
                  shreg <= shreg_shifted;
                  sdo_r <= head_next;
               end
            end
            if (sample_edge) begin
               if (full) begin
                  if (cnt == LAST) begin
                     done_r <= 1'b1;
                     cnt    <= '0;
`ifdef SPI_TRANSMITTER_DOUBLE_BUFFER_EN
                     if (hold_full) begin
                        shreg     <= hold;
                        hold_full <= 1'b0;
                     end else begin
                        shreg <= '0;
                        full  <= 1'b0;
                     end
`else
                     shreg <= '0;
                     full  <= 1'b0;
`endif
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end else if (!ur_seen) begin
                  underrun_r <= 1'b1;
                  ur_seen    <= 1'b1;
               end
            end
         end
      end
   end

`ifdef SPI_TRANSMITTER_DOUBLE_BUFFER_EN
   assign bus.ready = !hold_full;
`else
   assign bus.ready = !full && !active;
`endif

   assign bus.sdo        = use_gated_output ? (active & sdo_r) : sdo_r;
   assign bus.sdo_enable = active;
   assign bus.busy       = active;
   assign bus.done       = done_r;
   assign bus.underrun   = underrun_r;

endmodule

// File: tb/tb_spi_transmitter.sv
// Directed bench for spi_transmitter: one DUT with default mode, one with
// sample-on-leading-edge, LSB-first ordering; both share the ss/sclk pins.
module tb_spi_transmitter;

   logic clock;
   logic reset_n;
   logic ss;
   logic sclk;

   spi_transmitter_if #(.bitcount(8)) ifa ();
   spi_transmitter_if #(.bitcount(8)) ifb ();

   assign ifa.ss   = ss;
   assign ifa.sclk = sclk;
   assign ifb.ss   = ss;
   assign ifb.sclk = sclk;

   spi_transmitter #(
      .bitcount         (8),
      .ss_polarity      (1'b1),
      .sclk_polarity    (1'b0),
      .sclk_phase       (1'b1),
      .msb_first        (1'b1),
      .use_gated_output (1'b1)
   ) dut_a (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (ifa.slave)
   );

   spi_transmitter #(
      .bitcount         (8),
      .ss_polarity      (1'b1),
      .sclk_polarity    (1'b0),
      .sclk_phase       (1'b0),
      .msb_first        (1'b0),
      .use_gated_output (1'b1)
   ) dut_b (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (ifb.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks;
   int passed;

   int done_cnt_a, ur_cnt_a, done_cnt_b, ur_cnt_b;

   // Count status pulses, sampled on the falling edge.
   always @(negedge clock) begin
      if (ifa.done === 1'b1)     done_cnt_a++;
      if (ifa.underrun === 1'b1) ur_cnt_a++;
      if (ifb.done === 1'b1)     done_cnt_b++;
      if (ifb.underrun === 1'b1) ur_cnt_b++;
   end

   logic [15:0] rx_a, rx_b;
   logic [7:0]  done_tr_a, ready_tr_a;
   logic        mid_ready, first_b, busy_mid_a, en_mid_a, end_sdo_a;
   int          ur_pre_a;

   task automatic load_words(input logic [7:0] wa, input logic la,
                             input logic [7:0] wb, input logic lb);
      ifa.data = wa; ifa.load = la;
      ifb.data = wb; ifb.load = lb;
      @(negedge clock);
      ifa.load = 1'b0; ifb.load = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   // One ss frame of n sclk periods, 8 system clocks per sclk phase.
   task automatic frame(input int n, input int mid_at, input logic [7:0] mid_word);
      rx_a = '0; rx_b = '0; done_tr_a = '0; ready_tr_a = '0; mid_ready = 1'b0;
      ss = 1'b1;
      repeat (8) @(negedge clock);
      ur_pre_a   = ur_cnt_a;
      busy_mid_a = ifa.busy;
      en_mid_a   = ifa.sdo_enable;
      first_b    = ifb.sdo;
      for (int i = 0; i < n; i++) begin
         rx_b = {rx_b[14:0], ifb.sdo};
         sclk = 1'b1;
         if (i == mid_at) begin
            mid_ready = ifa.ready;
            ifa.data  = mid_word;
            ifa.load  = 1'b1;
            @(negedge clock);
            ifa.load  = 1'b0;
            repeat (7) @(negedge clock);
         end else begin
            repeat (8) @(negedge clock);
         end
         rx_a = {rx_a[14:0], ifa.sdo};
         sclk = 1'b0;
         if (i == n - 1) begin
            for (int k = 0; k < 8; k++) begin
               @(negedge clock);
               done_tr_a[k] = ifa.done;
            end
         end else begin
            repeat (8) @(negedge clock);
         end
      end
      ss = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         ready_tr_a[k] = ifa.ready;
      end
      end_sdo_a = ifa.sdo;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      ifa.data = 8'hFF; ifa.load = 1'b1;
      ifb.data = 8'hFF; ifb.load = 1'b1;
      repeat (4) @(negedge clock);
      ifa.load = 1'b0; ifb.load = 1'b0;
      reset_n = 1'b1;
      @(negedge clock);
      checks++; if (ifa.ready !== 1'b1) $display("FAIL reset_ready_a: got %b expected 1", ifa.ready); else passed++;
      checks++; if (ifa.busy !== 1'b0) $display("FAIL reset_busy_a: got %b expected 0", ifa.busy); else passed++;
      checks++; if (ifa.sdo_enable !== 1'b0) $display("FAIL reset_sdo_enable_a: got %b expected 0", ifa.sdo_enable); else passed++;
      checks++; if (ifa.sdo !== 1'b0) $display("FAIL reset_sdo_a: got %b expected 0", ifa.sdo); else passed++;
      checks++; if (ifa.done !== 1'b0) $display("FAIL reset_done_a: got %b expected 0", ifa.done); else passed++;
      checks++; if (ifa.underrun !== 1'b0) $display("FAIL reset_underrun_a: got %b expected 0", ifa.underrun); else passed++;
      checks++; if (ifb.ready !== 1'b1) $display("FAIL reset_ready_b: got %b expected 1", ifb.ready); else passed++;
   endtask

   task automatic test_basic;
      int d0, u0, db0, ub0;
      checks++; if (ifa.ready !== 1'b1) $display("FAIL basic_ready_before_load: got %b expected 1", ifa.ready); else passed++;
      load_words(8'hA5, 1'b1, 8'h01, 1'b1);
`ifdef SPI_TRANSMITTER_DOUBLE_BUFFER_EN
      checks++; if (ifa.ready !== 1'b1) $display("FAIL basic_ready_after_load: got %b expected 1", ifa.ready); else passed++;
`else
      checks++; if (ifa.ready !== 1'b0) $display("FAIL basic_ready_after_load: got %b expected 0", ifa.ready); else passed++;
`endif
      d0 = done_cnt_a; u0 = ur_cnt_a; db0 = done_cnt_b; ub0 = ur_cnt_b;
      frame(8, -1, 8'h00);
      checks++; if (rx_a[7:0] !== 8'hA5) $display("FAIL basic_bits_a: got %h expected a5", rx_a[7:0]); else passed++;
      checks++; if (done_cnt_a - d0 !== 1) $display("FAIL basic_done_count_a: got %0d expected 1", done_cnt_a - d0); else passed++;
      checks++; if (ur_cnt_a - u0 !== 0) $display("FAIL basic_underrun_a: got %0d expected 0", ur_cnt_a - u0); else passed++;
      checks++; if (done_tr_a !== 8'b0000_0100) $display("FAIL basic_done_latency: got %b expected 00000100", done_tr_a); else passed++;
`ifdef SPI_TRANSMITTER_DOUBLE_BUFFER_EN
      checks++; if (ready_tr_a !== 8'b1111_1111) $display("FAIL basic_ready_latency: got %b expected 11111111", ready_tr_a); else passed++;
`else
      checks++; if (ready_tr_a !== 8'b1111_1100) $display("FAIL basic_ready_latency: got %b expected 11111100", ready_tr_a); else passed++;
`endif
      checks++; if (busy_mid_a !== 1'b1) $display("FAIL basic_busy_in_frame: got %b expected 1", busy_mid_a); else passed++;
      checks++; if (en_mid_a !== 1'b1) $display("FAIL basic_sdo_enable_in_frame: got %b expected 1", en_mid_a); else passed++;
      checks++; if (end_sdo_a !== 1'b0) $display("FAIL basic_sdo_gated_after: got %b expected 0", end_sdo_a); else passed++;
      checks++; if (first_b !== 1'b1) $display("FAIL phase0_first_bit_b: got %b expected 1", first_b); else passed++;
      checks++; if (rx_b[7:0] !== 8'h80) $display("FAIL phase0_bits_b: got %h expected 80", rx_b[7:0]); else passed++;
      checks++; if (done_cnt_b - db0 !== 1) $display("FAIL phase0_done_count_b: got %0d expected 1", done_cnt_b - db0); else passed++;
      checks++; if (ur_cnt_b - ub0 !== 0) $display("FAIL phase0_underrun_b: got %0d expected 0", ur_cnt_b - ub0); else passed++;
   endtask

   task automatic test_underrun;
      int d0, u0;
      d0 = done_cnt_a; u0 = ur_cnt_a;
      frame(8, -1, 8'h00);
      checks++; if (ur_pre_a - u0 !== 1) $display("FAIL underrun_at_start: got %0d expected 1", ur_pre_a - u0); else passed++;
      checks++; if (ur_cnt_a - u0 !== 1) $display("FAIL underrun_total: got %0d expected 1", ur_cnt_a - u0); else passed++;
      checks++; if (rx_a[7:0] !== 8'h00) $display("FAIL underrun_bits: got %h expected 00", rx_a[7:0]); else passed++;
      checks++; if (done_cnt_a - d0 !== 0) $display("FAIL underrun_done: got %0d expected 0", done_cnt_a - d0); else passed++;
   endtask

   task automatic test_abort;
      int d0, u0;
      load_words(8'h5A, 1'b1, 8'h00, 1'b0);
      d0 = done_cnt_a; u0 = ur_cnt_a;
      frame(3, -1, 8'h00);
      checks++; if (rx_a[2:0] !== 3'b010) $display("FAIL abort_partial_bits: got %b expected 010", rx_a[2:0]); else passed++;
      checks++; if (done_cnt_a - d0 !== 0) $display("FAIL abort_done: got %0d expected 0", done_cnt_a - d0); else passed++;
      checks++; if (ur_cnt_a - u0 !== 0) $display("FAIL abort_underrun: got %0d expected 0", ur_cnt_a - u0); else passed++;
      checks++; if (ready_tr_a[7] !== 1'b1) $display("FAIL abort_ready: got %b expected 1", ready_tr_a[7]); else passed++;
      u0 = ur_cnt_a; d0 = done_cnt_a;
      frame(8, -1, 8'h00);
      checks++; if (ur_cnt_a - u0 !== 1) $display("FAIL abort_next_underrun: got %0d expected 1", ur_cnt_a - u0); else passed++;
      checks++; if (rx_a[7:0] !== 8'h00) $display("FAIL abort_next_bits: got %h expected 00", rx_a[7:0]); else passed++;
      checks++; if (done_cnt_a - d0 !== 0) $display("FAIL abort_next_done: got %0d expected 0", done_cnt_a - d0); else passed++;
   endtask

`ifdef SPI_TRANSMITTER_DOUBLE_BUFFER_EN
   task automatic test_back_to_back;
      int d0, u0;
      load_words(8'h3C, 1'b1, 8'h00, 1'b0);
      d0 = done_cnt_a; u0 = ur_cnt_a;
      frame(16, 3, 8'hC3);
      checks++; if (mid_ready !== 1'b1) $display("FAIL b2b_ready_mid_frame: got %b expected 1", mid_ready); else passed++;
      checks++; if (rx_a !== 16'h3CC3) $display("FAIL b2b_bits: got %h expected 3cc3", rx_a); else passed++;
      checks++; if (done_cnt_a - d0 !== 2) $display("FAIL b2b_done_count: got %0d expected 2", done_cnt_a - d0); else passed++;
      checks++; if (ur_cnt_a - u0 !== 0) $display("FAIL b2b_underrun: got %0d expected 0", ur_cnt_a - u0); else passed++;
   endtask
`else
   task automatic test_load_during_frame;
      int d0, u0;
      load_words(8'h1E, 1'b1, 8'h00, 1'b0);
      d0 = done_cnt_a; u0 = ur_cnt_a;
      frame(8, 3, 8'hFF);
      checks++; if (mid_ready !== 1'b0) $display("FAIL midload_ready: got %b expected 0", mid_ready); else passed++;
      checks++; if (rx_a[7:0] !== 8'h1E) $display("FAIL midload_bits: got %h expected 1e", rx_a[7:0]); else passed++;
      checks++; if (done_cnt_a - d0 !== 1) $display("FAIL midload_done: got %0d expected 1", done_cnt_a - d0); else passed++;
      checks++; if (ur_cnt_a - u0 !== 0) $display("FAIL midload_underrun: got %0d expected 0", ur_cnt_a - u0); else passed++;
      u0 = ur_cnt_a;
      frame(8, -1, 8'h00);
      checks++; if (ur_cnt_a - u0 !== 1) $display("FAIL midload_discarded: got %0d expected 1", ur_cnt_a - u0); else passed++;
      checks++; if (rx_a[7:0] !== 8'h00) $display("FAIL midload_next_bits: got %h expected 00", rx_a[7:0]); else passed++;
   endtask
`endif

   initial begin
      checks = 0; passed = 0;
      reset_n = 1'b0; ss = 1'b0; sclk = 1'b0;
      ifa.data = '0; ifa.load = 1'b0;
      ifb.data = '0; ifb.load = 1'b0;
      @(negedge clock);
      test_reset;
      test_basic;
      test_underrun;
      test_abort;
`ifdef SPI_TRANSMITTER_DOUBLE_BUFFER_EN
      test_back_to_back;
`else
      test_load_during_frame;
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
